// File: rtl/mux16_seq_if.sv
// Bundle of the word-request, 16:1 mux and serial-bit signals of mux16_seq.
// The producer/consumer side uses master; the serializer uses slave.
interface mux16_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_start;
  logic [3:0]  in_stop;
  logic        in_dir;
  logic        abort;
  logic [15:0] mux_in;
  logic [3:0]  sel;
  logic        mux_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_data;
  logic        bit_last;
  logic        busy;
  logic [7:0]  word_cnt;

  modport master (
    output in_valid, in_data, in_start, in_stop, in_dir, abort, mux_out, bit_ready,
    input  in_ready, mux_in, sel, bit_valid, bit_data, bit_last, busy, word_cnt
  );

  modport slave (
    input  in_valid, in_data, in_start, in_stop, in_dir, abort, mux_out, bit_ready,
    output in_ready, mux_in, sel, bit_valid, bit_data, bit_last, busy, word_cnt
  );
endinterface

// File: rtl/mux16_seq.sv
// Serializes a 16-bit word through an external 16:1 mux by stepping its select
// from a start to a stop value, one bit per valid/ready transfer.
module mux16_seq (
  input  logic         clk,
  input  logic         rst_n,
  mux16_seq_if.slave   bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic        ready_en;
  logic [15:0] mux_q;
  logic [3:0]  sel_q;
  logic [3:0]  stop_q;
  logic        dir_q;
  logic [7:0]  cnt_q;
  logic        in_ready_c, bit_valid_c, bit_last_c;
  logic        at_stop, accept, xfer;

  // Abort outranks both a new word and a pending bit transfer.
  assign at_stop = (sel_q == stop_q);
  assign accept  = bus.in_valid & in_ready_c & ~bus.abort;
  assign xfer    = bit_valid_c & bus.bit_ready & ~bus.abort;

  // NOTE: sequential state uses non-blocking (<=) so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = SHIFT;
      SHIFT: if (bus.abort || (xfer && at_stop)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    bit_valid_c = 1'b0;
    bit_last_c  = 1'b0;
    unique case (state)
      IDLE:  in_ready_c = ready_en;
      SHIFT: begin
        bit_valid_c = 1'b1;
        bit_last_c  = at_stop;
      end
      default: ;
    endcase
  end

  // ready_en keeps in_ready low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      mux_q    <= 16'h0000;
      sel_q    <= 4'h0;
      stop_q   <= 4'h0;
      dir_q    <= 1'b0;
      cnt_q    <= 8'h00;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        mux_q  <= bus.in_data;
        sel_q  <= bus.in_start;
        stop_q <= bus.in_stop;
        dir_q  <= bus.in_dir;
      end else if (xfer) begin
        if (at_stop) cnt_q <= cnt_q + 8'd1;
        else         sel_q <= dir_q ? sel_q - 4'd1 : sel_q + 4'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.bit_valid = bit_valid_c;
  assign bus.busy      = bit_valid_c;
  assign bus.bit_last  = bit_last_c;
  assign bus.bit_data  = bus.mux_out;
  assign bus.mux_in    = mux_q;
  assign bus.sel       = sel_q;
  assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_mux16_seq.sv
// Randomized bench for mux16_seq: each bit is predicted from the word and the
// start/stop/direction rules with plain modular arithmetic.
module tb_mux16_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;
  logic [15:0] last_data = 16'h0000;

  mux16_seq_if bus ();

  // External 16:1 mux that the serializer steers.
  assign bus.mux_out = bus.mux_in[bus.sel];

  mux16_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_sel(input int start, input logic dir, input int k);
    int v;
    v = dir ? (start - k) : (start + k);
    v = ((v % 16) + 16) % 16;
    return v[3:0];
  endfunction

  // Sends one word and follows it bit by bit; abort_k/rst_k cut it short at that bit index.
  task automatic send_word(input logic [15:0] data, input int start, input int stop,
                           input logic dir, input int ready_pct, input int stall_k,
                           input int abort_k, input int rst_k);
    int n, k, waited, stalls, rnd_stalls;
    logic [3:0] s;
    logic rdy;
    n = dir ? ((start - stop + 16) % 16) + 1 : ((stop - start + 16) % 16) + 1;
    waited = 0;
    while (!bus.in_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_start = start[3:0];
    bus.in_stop  = stop[3:0];
    bus.in_dir   = dir;
    @(negedge clk);
    bus.in_valid = 1'b0;
    last_data    = data;
    check("mux_in_load", 32'(bus.mux_in), 32'(data));
    check("busy_shift", 32'(bus.busy), 32'd1);
    check("in_ready_shift", 32'(bus.in_ready), 32'd0);
    k = 0;
    stalls = 0;
    rnd_stalls = 0;
    while (k < n) begin
      s = exp_sel(start, dir, k);
      check("sel", 32'(bus.sel), 32'(s));
      check("bit_valid", 32'(bus.bit_valid), 32'd1);
      check("bit_data", 32'(bus.bit_data), 32'(data[s]));
      check("bit_last", 32'(bus.bit_last), 32'(k == n - 1));
      check("mux_in_hold", 32'(bus.mux_in), 32'(data));
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_sel", 32'(bus.sel), 32'd0);
        check("rst_mux_in", 32'(bus.mux_in), 32'd0);
        check("rst_bit_valid", 32'(bus.bit_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_word_cnt", 32'(bus.word_cnt), 32'd0);
        bus.bit_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        exp_cnt   = 0;
        last_data = 16'h0000;
        return;
      end
      if (k == stall_k && stalls < 3) begin
        rdy = 1'b0;
        stalls++;
      end else if (rnd_stalls < 6 && int'($urandom_range(99)) >= ready_pct) begin
        rdy = 1'b0;
        rnd_stalls++;
      end else begin
        rdy = 1'b1;
      end
      bus.bit_ready = rdy;
      bus.abort     = (k == abort_k);
      // Requests arriving mid-word must be ignored.
      bus.in_valid  = 1'($urandom_range(1));
      bus.in_data   = 16'($urandom);
      bus.in_start  = 4'($urandom);
      @(negedge clk);
      if (k == abort_k) begin
        bus.abort     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.bit_ready = 1'b0;
        check("abort_bit_valid", 32'(bus.bit_valid), 32'd0);
        check("abort_sel_hold", 32'(bus.sel), 32'(s));
        check("abort_mux_hold", 32'(bus.mux_in), 32'(data));
        check("abort_word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
        return;
      end
      if (rdy) begin
        k++;
        rnd_stalls = 0;
      end
    end
    bus.in_valid  = 1'b0;
    bus.bit_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    check("done_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("done_in_ready", 32'(bus.in_ready), 32'd1);
    check("done_mux_in", 32'(bus.mux_in), 32'(data));
    check("word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
  endtask

  initial begin
    int st;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'h0000;
    bus.in_start  = 4'h0;
    bus.in_stop   = 4'h0;
    bus.in_dir    = 1'b0;
    bus.abort     = 1'b0;
    bus.bit_ready = 1'b0;
    #3;
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_bit_valid", 32'(bus.bit_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_sel", 32'(bus.sel), 32'd0);
    check("reset_mux_in", 32'(bus.mux_in), 32'd0);
    check("reset_word_cnt", 32'(bus.word_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed words: full sweep, wrap up, count down, stall at sel 5, single bit.
    send_word(16'h3f1a, 0, 15, 1'b0, 100, -1, -1, -1);
    send_word(16'h11ad, 14, 1, 1'b0, 100, -1, -1, -1);
    send_word(16'h11ad, 3, 0, 1'b1, 100, -1, -1, -1);
    send_word(16'h3f1a, 0, 15, 1'b0, 100, 5, -1, -1);
    send_word(16'ha5c3, 7, 7, 1'b1, 100, -1, -1, -1);

    // Abort at the 4th bit, then abort together with a request while idle.
    send_word(16'h3f1a, 0, 15, 1'b0, 100, -1, 3, -1);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hbeef;
    bus.in_start = 4'h2;
    bus.abort    = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    check("idle_abort_busy", 32'(bus.busy), 32'd0);
    check("idle_abort_mux_in", 32'(bus.mux_in), 32'(last_data));
    check("idle_abort_word_cnt", 32'(bus.word_cnt), 32'(exp_cnt));
    send_word(16'h11ad, 14, 1, 1'b0, 100, -1, -1, -1);

    // Reset mid-word at sel 9, then a normal word.
    send_word(16'h3f1a, 0, 15, 1'b0, 100, -1, -1, 9);
    send_word(16'h0f0f, 4, 11, 1'b0, 100, -1, -1, -1);

    // Random back-to-back words with random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      send_word(16'($urandom), int'($urandom_range(15)), int'($urandom_range(15)),
                1'($urandom_range(1)), int'($urandom_range(100, 30)), -1, -1, -1);
    end

    // Enough single-bit words to wrap the word counter.
    for (int i = 0; i < 260; i++) begin
      st = int'($urandom_range(15));
      send_word(16'($urandom), st, st, 1'($urandom_range(1)), 100, -1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
